// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage
//   ID/EX pipeline register with load-use hazard detection and control-hazard
//   flush for a 5-stage RISC-V pipeline.
//
//   Optional feature macro: HAZARD_PERF_EN
//     When defined, adds 32-bit StallCount / FlushCount event counters.
//
//   Ports
//     clk, reset                  clock, async active-high reset
//     ID_*                        decoded instruction fields from the ID stage
//     Flush                       taken branch/jump resolved in EX this cycle
//     Freeze                      global pipeline hold
//     PCWrite, IF_ID_Write        front-end enables (combinational)
//     IF_ID_Flush                 zero the IF/ID instruction (combinational)
//     ID_EX_*                     registered fields presented to EX / forwarding
//     StallCount, FlushCount      event counters (HAZARD_PERF_EN only)
module id_ex_hazard_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      ID_Rs1,
  input  logic [4:0]      ID_Rs2,
  input  logic [4:0]      ID_Rd,
  input  logic            ID_UsesRs1,
  input  logic            ID_UsesRs2,
  input  logic [XLEN-1:0] ID_ReadData1,
  input  logic [XLEN-1:0] ID_ReadData2,
  input  logic [XLEN-1:0] ID_Imm,
  input  logic [XLEN-1:0] ID_PC,
  input  logic            ID_RegWrite,
  input  logic            ID_MemRead,
  input  logic            ID_MemWrite,
  input  logic            ID_MemtoReg,
  input  logic            ID_ALUSrc,
  input  logic            ID_Branch,
  input  logic [3:0]      ID_ALUCtrl,
  input  logic            Flush,
  input  logic            Freeze,
  output logic            PCWrite,
  output logic            IF_ID_Write,
  output logic            IF_ID_Flush,
  output logic [4:0]      ID_EX_Rs1,
  output logic [4:0]      ID_EX_Rs2,
  output logic [4:0]      ID_EX_Rd,
  output logic [XLEN-1:0] ID_EX_ReadData1,
  output logic [XLEN-1:0] ID_EX_ReadData2,
  output logic [XLEN-1:0] ID_EX_Imm,
  output logic [XLEN-1:0] ID_EX_PC,
  output logic            ID_EX_RegWrite,
  output logic            ID_EX_MemRead,
  output logic            ID_EX_MemWrite,
  output logic            ID_EX_MemtoReg,
  output logic            ID_EX_ALUSrc,
  output logic            ID_EX_Branch,
  output logic [3:0]      ID_EX_ALUCtrl
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]     StallCount,
  output logic [31:0]     FlushCount
`endif
);

  // Action taken on the next edge, in priority order.
  typedef enum logic [1:0] {
    ACT_PASS   = 2'd0,
    ACT_FREEZE = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_STALL  = 2'd3
  } act_e;

  act_e w_act;
  logic w_load_use;
  logic w_flush_eff;
  logic r_flush_pending;

  // A store whose rs2 is the load destination gets its data through the
  // load-store forwarding path, so only rs1 of a store can cause a stall.
  assign w_load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                      ((ID_UsesRs1 && (ID_Rs1 == ID_EX_Rd)) ||
                       (ID_UsesRs2 && (ID_Rs2 == ID_EX_Rd) && !ID_MemWrite));

  // A flush seen during Freeze is remembered and applied once Freeze drops.
  assign w_flush_eff = Flush || r_flush_pending;

  always_comb begin
    w_act = ACT_PASS;
    if (Freeze)           w_act = ACT_FREEZE;
    else if (w_flush_eff) w_act = ACT_FLUSH;
    else if (w_load_use)  w_act = ACT_STALL;
  end

  always_comb begin
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    if (!reset) begin
      case (w_act)
        ACT_FREEZE: begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
        end
        ACT_FLUSH:  IF_ID_Flush = 1'b1;
        ACT_STALL: begin
          PCWrite     = 1'b0;
          IF_ID_Write = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush_pending <= 1'b0;
      ID_EX_Rs1       <= '0;
      ID_EX_Rs2       <= '0;
      ID_EX_Rd        <= '0;
      ID_EX_ReadData1 <= '0;
      ID_EX_ReadData2 <= '0;
      ID_EX_Imm       <= '0;
      ID_EX_PC        <= '0;
      ID_EX_RegWrite  <= 1'b0;
      ID_EX_MemRead   <= 1'b0;
      ID_EX_MemWrite  <= 1'b0;
      ID_EX_MemtoReg  <= 1'b0;
      ID_EX_ALUSrc    <= 1'b0;
      ID_EX_Branch    <= 1'b0;
      ID_EX_ALUCtrl   <= '0;
    end else begin
      case (w_act)
        ACT_FREEZE: begin
          if (Flush) r_flush_pending <= 1'b1;
        end
        ACT_FLUSH, ACT_STALL: begin
          // Bubble: all-zero NOP that the forwarding unit can never match.
          if (w_act == ACT_FLUSH) r_flush_pending <= 1'b0;
          ID_EX_Rs1       <= '0;
          ID_EX_Rs2       <= '0;
          ID_EX_Rd        <= '0;
          ID_EX_ReadData1 <= '0;
          ID_EX_ReadData2 <= '0;
          ID_EX_Imm       <= '0;
          ID_EX_PC        <= '0;
          ID_EX_RegWrite  <= 1'b0;
          ID_EX_MemRead   <= 1'b0;
          ID_EX_MemWrite  <= 1'b0;
          ID_EX_MemtoReg  <= 1'b0;
          ID_EX_ALUSrc    <= 1'b0;
          ID_EX_Branch    <= 1'b0;
          ID_EX_ALUCtrl   <= '0;
        end
        default: begin
          ID_EX_Rs1       <= ID_Rs1;
          ID_EX_Rs2       <= ID_Rs2;
          ID_EX_Rd        <= ID_Rd;
          ID_EX_ReadData1 <= ID_ReadData1;
          ID_EX_ReadData2 <= ID_ReadData2;
          ID_EX_Imm       <= ID_Imm;
          ID_EX_PC        <= ID_PC;
          ID_EX_RegWrite  <= ID_RegWrite;
          ID_EX_MemRead   <= ID_MemRead;
          ID_EX_MemWrite  <= ID_MemWrite;
          ID_EX_MemtoReg  <= ID_MemtoReg;
          ID_EX_ALUSrc    <= ID_ALUSrc;
          ID_EX_Branch    <= ID_Branch;
          ID_EX_ALUCtrl   <= ID_ALUCtrl;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (w_act == ACT_STALL) StallCount <= StallCount + 32'd1;
      if (w_act == ACT_FLUSH) FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
module tb_id_ex_hazard_stage;

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [31:0] d1, d2, imm, pc;
    logic        rw, mr, mw, m2r, as, br;
    logic [3:0]  alu;
  } ins_t;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    bit u1, u2, mr, mw, rw, fl, fz;
    bit e_pcw, e_ifw, e_iff;
    bit e_rw, e_mr, e_mw;
    logic [4:0] e_rd;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] ID_Rs1, ID_Rs2, ID_Rd;
  logic ID_UsesRs1, ID_UsesRs2;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm, ID_PC;
  logic ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_Branch;
  logic [3:0] ID_ALUCtrl;
  logic Flush, Freeze;
  logic PCWrite, IF_ID_Write, IF_ID_Flush;
  logic [4:0] ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd;
  logic [31:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, ID_EX_PC;
  logic ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_Branch;
  logic [3:0] ID_EX_ALUCtrl;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCount, FlushCount;
`endif

  id_ex_hazard_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2), .ID_Rd(ID_Rd),
    .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_Imm(ID_Imm), .ID_PC(ID_PC),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_Branch(ID_Branch),
    .ID_ALUCtrl(ID_ALUCtrl),
    .Flush(Flush), .Freeze(Freeze),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Rs1(ID_EX_Rs1), .ID_EX_Rs2(ID_EX_Rs2), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
    .ID_EX_Imm(ID_EX_Imm), .ID_EX_PC(ID_EX_PC),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
    .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_Branch(ID_EX_Branch),
    .ID_EX_ALUCtrl(ID_EX_ALUCtrl)
`ifdef HAZARD_PERF_EN
    , .StallCount(StallCount), .FlushCount(FlushCount)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // EX slot contents, pending-flush memory and event counts.
  ins_t        m_ex;
  bit          m_pend;
  bit          m_bubble;
  int unsigned m_stall, m_flush;
  ins_t        cur_id;
  bit          cur_fl, cur_fz;
  // What happens at the coming edge: 0 capture, 1 hold, 2 squash, 3 stall.
  int          m_kind;

  function automatic bit needs_loaded_value(input ins_t ex, input ins_t id);
    bit r1, r2;
    if (!ex.mr || ex.rd == 0) return 0;
    r1 = id.u1 && id.rs1 == ex.rd;
    r2 = id.u2 && id.rs2 == ex.rd && !id.mw;
    return r1 || r2;
  endfunction

  task automatic model_reset();
    m_ex = '0; m_pend = 0; m_bubble = 1; m_stall = 0; m_flush = 0;
  endtask

  task automatic drive(input ins_t x, input bit fl, input bit fz);
    ID_Rs1 = x.rs1; ID_Rs2 = x.rs2; ID_Rd = x.rd;
    ID_UsesRs1 = x.u1; ID_UsesRs2 = x.u2;
    ID_ReadData1 = x.d1; ID_ReadData2 = x.d2; ID_Imm = x.imm; ID_PC = x.pc;
    ID_RegWrite = x.rw; ID_MemRead = x.mr; ID_MemWrite = x.mw;
    ID_MemtoReg = x.m2r; ID_ALUSrc = x.as; ID_Branch = x.br; ID_ALUCtrl = x.alu;
    Flush = fl; Freeze = fz;
  endtask

  // Drive one instruction mid-cycle and check the combinational enables.
  task automatic apply(input ins_t x, input bit fl, input bit fz);
    bit e_pcw, e_iff;
    @(negedge clk);
    cur_id = x; cur_fl = fl; cur_fz = fz;
    drive(x, fl, fz);
    #1;
    if (fz)                              m_kind = 1;
    else if (fl || m_pend)               m_kind = 2;
    else if (needs_loaded_value(m_ex, x)) m_kind = 3;
    else                                 m_kind = 0;
    e_pcw = (m_kind == 0) || (m_kind == 2);
    e_iff = (m_kind == 2);
    if (reset) begin e_pcw = 1; e_iff = 0; end
    chk("PCWrite", PCWrite, e_pcw);
    chk("IF_ID_Write", IF_ID_Write, e_pcw);
    chk("IF_ID_Flush", IF_ID_Flush, e_iff);
  endtask

  task automatic check_regs();
    if (!m_bubble) begin
      chk("ID_EX_Rs1", ID_EX_Rs1, m_ex.rs1);
      chk("ID_EX_Rs2", ID_EX_Rs2, m_ex.rs2);
    end
    chk("ID_EX_Rd", ID_EX_Rd, m_ex.rd);
    chk("ID_EX_ReadData1", ID_EX_ReadData1, m_ex.d1);
    chk("ID_EX_ReadData2", ID_EX_ReadData2, m_ex.d2);
    chk("ID_EX_Imm", ID_EX_Imm, m_ex.imm);
    chk("ID_EX_PC", ID_EX_PC, m_ex.pc);
    chk("ID_EX_ctrl", {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite,
                       ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_Branch},
        {m_ex.rw, m_ex.mr, m_ex.mw, m_ex.m2r, m_ex.as, m_ex.br});
    chk("ID_EX_ALUCtrl", ID_EX_ALUCtrl, m_ex.alu);
`ifdef HAZARD_PERF_EN
    chk("StallCount", StallCount, m_stall);
    chk("FlushCount", FlushCount, m_flush);
`endif
  endtask

  // Clock the edge, advance the model, check the registered outputs.
  task automatic advance();
    @(posedge clk);
    #1;
    case (m_kind)
      1: if (cur_fl) m_pend = 1;
      2: begin m_ex = '0; m_pend = 0; m_bubble = 1; m_flush++; end
      3: begin m_ex = '0; m_bubble = 1; m_stall++; end
      default: begin m_ex = cur_id; m_ex.u1 = 0; m_ex.u2 = 0; m_bubble = 0; end
    endcase
    check_regs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive('0, 0, 0);
    reset = 1;
    #1;
    model_reset();
    chk("reset_PCWrite", PCWrite, 1);
    chk("reset_IF_ID_Write", IF_ID_Write, 1);
    chk("reset_IF_ID_Flush", IF_ID_Flush, 0);
    check_regs();
    @(negedge clk);
    reset = 0;
  endtask

  function automatic ins_t mk(input logic [4:0] rs1, rs2, rd, input bit u1, u2,
                              mr, mw, rw, input int seed);
    ins_t x;
    x = '0;
    x.rs1 = rs1; x.rs2 = rs2; x.rd = rd; x.u1 = u1; x.u2 = u2;
    x.mr = mr; x.mw = mw; x.rw = rw; x.m2r = mr;
    x.d1 = 32'h1000_0000 + seed; x.d2 = 32'h2000_0000 + seed;
    x.imm = 32'h0000_0040 + seed; x.pc = 32'h0000_1000 + 4 * seed;
    x.as = mr | mw; x.alu = seed[3:0];
    return x;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t x;
    x = '0;
    x.rs1 = 5'($urandom_range(0, 3)); x.rs2 = 5'($urandom_range(0, 3));
    x.rd  = 5'($urandom_range(0, 3));
    x.u1 = 1'($urandom); x.u2 = 1'($urandom);
    x.d1 = $urandom; x.d2 = $urandom; x.imm = $urandom; x.pc = $urandom;
    x.rw = 1'($urandom); x.mr = 1'($urandom); x.mw = 1'($urandom);
    x.m2r = 1'($urandom); x.as = 1'($urandom); x.br = 1'($urandom);
    x.alu = 4'($urandom);
    return x;
  endfunction

  vec_t vecs[15];

  initial begin
    ins_t x;
    reset = 1;
    drive('0, 0, 0);
    model_reset();

    // rs1 rs2 rd u1 u2 mr mw rw fl fz | pcw ifw iff | rw mr mw rd
    vecs[0]  = '{5'd1, 5'd0, 5'd5, 1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1, 1, 0, 5'd5}; // lw x5
    vecs[1]  = '{5'd5, 5'd0, 5'd7, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0}; // add uses x5: stall
    vecs[2]  = '{5'd5, 5'd0, 5'd7, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 5'd7}; // add proceeds
    vecs[3]  = '{5'd2, 5'd0, 5'd5, 1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1, 1, 0, 5'd5}; // lw x5
    vecs[4]  = '{5'd2, 5'd5, 5'd0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 5'd0}; // sw data=x5: no stall
    vecs[5]  = '{5'd3, 5'd0, 5'd0, 1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1, 1, 0, 5'd0}; // lw x0
    vecs[6]  = '{5'd0, 5'd0, 5'd8, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 5'd8}; // reads x0: no stall
    vecs[7]  = '{5'd1, 5'd0, 5'd6, 1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1, 1, 0, 5'd6}; // lw x6
    vecs[8]  = '{5'd6, 5'd0, 5'd7, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0}; // lw x7 via x6: stall
    vecs[9]  = '{5'd6, 5'd0, 5'd7, 1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1, 1, 0, 5'd7}; // lw x7 proceeds
    vecs[10] = '{5'd0, 5'd7, 5'd9, 0, 1, 0, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0, 5'd0}; // hazard + flush
    vecs[11] = '{5'd0, 5'd7, 5'd9, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 5'd9}; // refetched add
    vecs[12] = '{5'd9, 5'd0, 5'd9, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 5'd9}; // frozen: hold
    vecs[13] = '{5'd1, 5'd0, 5'd9, 1, 0, 1, 0, 1, 0, 0, 1, 1, 0, 1, 1, 0, 5'd9}; // lw x9
    vecs[14] = '{5'd9, 5'd9, 5'd4, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 5'd4}; // fields unused

    do_reset();
    for (int i = 0; i < 15; i++) begin
      x = mk(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].u1, vecs[i].u2,
             vecs[i].mr, vecs[i].mw, vecs[i].rw, i);
      apply(x, vecs[i].fl, vecs[i].fz);
      chk($sformatf("vec%0d_PCWrite", i), PCWrite, vecs[i].e_pcw);
      chk($sformatf("vec%0d_IF_ID_Write", i), IF_ID_Write, vecs[i].e_ifw);
      chk($sformatf("vec%0d_IF_ID_Flush", i), IF_ID_Flush, vecs[i].e_iff);
      advance();
      chk($sformatf("vec%0d_ctrl", i), {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite},
          {vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw});
      chk($sformatf("vec%0d_Rd", i), ID_EX_Rd, vecs[i].e_rd);
    end

    // Flush arriving during a 3-cycle Freeze takes effect afterwards.
    do_reset();
    apply(mk(5'd1, 5'd0, 5'd3, 1, 0, 1, 0, 1, 40), 0, 0); advance();
    for (int c = 0; c < 3; c++) begin
      apply(mk(5'd2, 5'd2, 5'd12, 1, 1, 0, 0, 1, 50 + c), c == 0, 1);
      chk("frz_IF_ID_Flush", IF_ID_Flush, 0);
      chk("frz_PCWrite", PCWrite, 0);
      advance();
      chk("frz_Rd_held", ID_EX_Rd, 5'd3);
      chk("frz_MemRead_held", ID_EX_MemRead, 1);
    end
    apply(mk(5'd2, 5'd2, 5'd12, 1, 1, 0, 0, 1, 60), 0, 0);
    chk("postfrz_IF_ID_Flush", IF_ID_Flush, 1);
    chk("postfrz_PCWrite", PCWrite, 1);
    advance();
    chk("postfrz_bubble", {ID_EX_RegWrite, ID_EX_Rd}, 6'd0);
    apply(mk(5'd2, 5'd2, 5'd12, 1, 1, 0, 0, 1, 61), 0, 0);
    chk("pend_cleared", IF_ID_Flush, 0);
    advance();
`ifdef HAZARD_PERF_EN
    chk("frz_FlushCount", FlushCount, 1);
`endif

    // Flush together with a load-use hazard: flush wins.
    do_reset();
    apply(mk(5'd1, 5'd0, 5'd5, 1, 0, 1, 0, 1, 70), 0, 0); advance();
    apply(mk(5'd5, 5'd0, 5'd7, 1, 0, 0, 0, 1, 71), 1, 0);
    chk("flhz_IF_ID_Flush", IF_ID_Flush, 1);
    chk("flhz_PCWrite", PCWrite, 1);
    advance();
    chk("flhz_bubble", {ID_EX_RegWrite, ID_EX_MemRead, ID_EX_Rd}, 7'd0);
`ifdef HAZARD_PERF_EN
    chk("flhz_FlushCount", FlushCount, 1);
    chk("flhz_StallCount", StallCount, 0);
`endif

    // Asynchronous reset between edges while a stall is active.
    do_reset();
    apply(mk(5'd1, 5'd0, 5'd5, 1, 0, 1, 0, 1, 80), 0, 0); advance();
    apply(mk(5'd5, 5'd0, 5'd7, 1, 0, 0, 0, 1, 81), 0, 0);
    chk("stall_before_reset", PCWrite, 0);
    #2;
    reset = 1;
    #1;
    model_reset();
    chk("areset_MemRead", ID_EX_MemRead, 0);
    chk("areset_Rd", ID_EX_Rd, 0);
    chk("areset_PCWrite", PCWrite, 1);
    @(negedge clk);
    reset = 0;
    apply(mk(5'd5, 5'd0, 5'd7, 1, 0, 0, 0, 1, 82), 0, 0);
    chk("postreset_PCWrite", PCWrite, 1);
    advance();
    chk("postreset_Rs1", ID_EX_Rs1, 5'd5);
    chk("postreset_RegWrite", ID_EX_RegWrite, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      apply(rnd_ins(), $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
